// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: one multiplier bit per clock, full 2*WIDTH-bit product.
// Define MULT_SIGNED_EN to compile in two's-complement operation selected by is_signed.
//
// state  | meaning
// -------+------------------------------------------------
// S_IDLE | ready for a new operation, p holds last product
// S_RUN  | one shift-add step per clock, WIDTH steps
// S_DONE | done pulse, p valid
module seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t               state, state_nxt;
    logic [WIDTH-1:0]     mcand, acc_hi, acc_lo;
    logic [CW-1:0]        cnt;
    logic [WIDTH:0]       sum;
    logic                 last;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic                 neg_in;
    logic [2*WIDTH-1:0]   prod, p_final;

`ifdef MULT_SIGNED_EN
    logic neg;
    logic a_neg, b_neg;

    assign a_neg   = is_signed & a[WIDTH-1];
    assign b_neg   = is_signed & b[WIDTH-1];
    // -(-2^(W-1)) wraps to 2^(W-1), which is the exact unsigned magnitude
    assign a_mag   = a_neg ? -a : a;
    assign b_mag   = b_neg ? -b : b;
    assign neg_in  = a_neg ^ b_neg;
    assign p_final = neg ? -prod : prod;
`else
    logic unused_is_signed;

    assign unused_is_signed = is_signed;
    assign a_mag   = a;
    assign b_mag   = b;
    assign neg_in  = 1'b0;
    assign p_final = prod;
`endif

    assign last = (cnt == CW'(WIDTH - 1));
    assign sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
    // {sum, lower} shifted right by one
    assign prod = {sum, acc_lo[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (last)  state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign ready = (state == S_IDLE);
    assign busy  = (state == S_RUN);
    assign done  = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            cnt    <= '0;
            p      <= '0;
`ifdef MULT_SIGNED_EN
            neg    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mcand  <= a_mag;
                        acc_hi <= '0;
                        acc_lo <= b_mag;
                        cnt    <= '0;
`ifdef MULT_SIGNED_EN
                        neg    <= neg_in;
`endif
                    end
                end
                S_RUN: begin
                    acc_hi <= prod[2*WIDTH-1:WIDTH];
                    acc_lo <= prod[WIDTH-1:0];
                    cnt    <= cnt + 1'b1;
                    if (last) p <= p_final;
                end
                default: ;
            endcase
        end
    end

`ifndef MULT_SIGNED_EN
    logic unused_neg_in;
    assign unused_neg_in = neg_in;
`endif

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier at WIDTH=4 and WIDTH=8; signed vectors when
// MULT_SIGNED_EN is defined.
module tb_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst;
    logic        start4, s4, ready4, busy4, done4;
    logic [3:0]  a4, b4;
    logic [7:0]  p4;
    logic        start8, s8, ready8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_multiplier #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .is_signed(s4),
        .ready(ready4), .busy(busy4), .done(done4), .p(p4)
    );

    seq_multiplier #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .is_signed(s8),
        .ready(ready8), .busy(busy8), .done(done8), .p(p8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rbd4(input string tag, input logic [2:0] exp);
        chk(tag, 64'({ready4, busy4, done4}), 64'(exp));
    endtask

    task automatic rbd8(input string tag, input logic [2:0] exp);
        chk(tag, 64'({ready8, busy8, done8}), 64'(exp));
    endtask

    task automatic op4(input logic [3:0] ta, input logic [3:0] tb, input logic ts,
                       input logic [7:0] ep, input string tag);
        rbd4({tag, ".idle"}, 3'b100);
        a4 = ta; b4 = tb; s4 = ts; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        rbd4({tag, ".run"}, 3'b010);
        repeat (3) begin
            @(posedge clk); #1;
            rbd4({tag, ".run"}, 3'b010);
        end
        @(posedge clk); #1;
        rbd4({tag, ".done"}, 3'b001);
        chk({tag, ".p"}, 64'(p4), 64'(ep));
        @(posedge clk); #1;
        rbd4({tag, ".ready"}, 3'b100);
        chk({tag, ".hold"}, 64'(p4), 64'(ep));
    endtask

    task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic ts,
                       input logic [15:0] ep, input string tag);
        rbd8({tag, ".idle"}, 3'b100);
        a8 = ta; b8 = tb; s8 = ts; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        a8 = ~ta; b8 = ~tb;
        rbd8({tag, ".run"}, 3'b010);
        repeat (7) begin
            @(posedge clk); #1;
            if ({ready8, busy8, done8} !== 3'b010) rbd8({tag, ".run"}, 3'b010);
        end
        @(posedge clk); #1;
        rbd8({tag, ".done"}, 3'b001);
        chk({tag, ".p"}, 64'(p8), 64'(ep));
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0]  ra, rb;
        logic        rs;
        logic [15:0] ep;

        rst = 1'b1;
        start4 = 1'b0; a4 = '0; b4 = '0; s4 = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; s8 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // reset state, start low
        repeat (3) begin
            @(posedge clk); #1;
            rbd4("rst_state", 3'b100);
            chk("rst_p", 64'(p4), 64'h0);
        end

        op4(4'd15, 4'd15, 1'b0, 8'hE1, "u15x15");
        op4(4'd0,  4'd9,  1'b0, 8'h00, "u0x9");
        op4(4'd9,  4'd0,  1'b0, 8'h00, "u9x0");
        op4(4'd13, 4'd11, 1'b0, 8'h8F, "u13x11");

`ifdef MULT_SIGNED_EN
        op4(4'b1000, 4'b0111, 1'b1, 8'hC8, "s-8x7");
        op4(4'b1000, 4'b1000, 1'b1, 8'h40, "s-8x-8");
        op4(4'b0011, 4'b1011, 1'b1, 8'hF1, "s3x-5");
        op4(4'b1111, 4'b1111, 1'b1, 8'h01, "s-1x-1");
        op4(4'b1000, 4'b0111, 1'b0, 8'h38, "u8x7");
`else
        op4(4'b1000, 4'b0111, 1'b1, 8'h38, "ign_signed");
`endif

        // start pulses during an operation in flight are ignored
        a4 = 4'd15; b4 = 4'd15; s4 = 1'b0; start4 = 1'b1;
        @(posedge clk); #1;
        rbd4("flight.run", 3'b010);
        a4 = 4'd1; b4 = 4'd1;
        repeat (3) begin
            @(posedge clk); #1;
            rbd4("flight.run", 3'b010);
        end
        start4 = 1'b0;
        @(posedge clk); #1;
        rbd4("flight.done", 3'b001);
        chk("flight.p", 64'(p4), 64'hE1);
        repeat (2) begin
            @(posedge clk); #1;
            rbd4("flight.noqueue", 3'b100);
        end

        // start held: back-to-back ops, done every 6 cycles
        a4 = 4'd2; b4 = 4'd3; start4 = 1'b1;
        for (int i = 0; i < 18; i++) begin
            @(posedge clk); #1;
            if (i % 6 == 4) begin
                rbd4("held.done", 3'b001);
                chk("held.p", 64'(p4), 64'h06);
            end else if (i % 6 == 5) begin
                rbd4("held.idle", 3'b100);
            end else begin
                rbd4("held.run", 3'b010);
            end
        end
        start4 = 1'b0;

        // reset at edge k+2 aborts the operation
        a4 = 4'd15; b4 = 4'd15; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        rbd4("abort.run", 3'b010);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rbd4("abort.rst", 3'b100);
        chk("abort.p", 64'(p4), 64'h0);
        rst = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if ({ready4, busy4, done4} !== 3'b100) rbd4("abort.nodone", 3'b100);
        end
        chk("abort.p_hold", 64'(p4), 64'h0);
        op4(4'd7, 4'd9, 1'b0, 8'h3F, "after_abort");

        // start held through reset is accepted on the first released edge
        rst = 1'b1; a4 = 4'd3; b4 = 4'd5; start4 = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            rbd4("rststart.idle", 3'b100);
            chk("rststart.p", 64'(p4), 64'h0);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        start4 = 1'b0;
        rbd4("rststart.run", 3'b010);
        repeat (3) begin
            @(posedge clk); #1;
            rbd4("rststart.run", 3'b010);
        end
        @(posedge clk); #1;
        rbd4("rststart.done", 3'b001);
        chk("rststart.p", 64'(p4), 64'h0F);

        // WIDTH=8 directed
        op8(8'd255, 8'd255, 1'b0, 16'hFE01, "w8.max");
        op8(8'd0,   8'd77,  1'b0, 16'h0000, "w8.zero");
        op8(8'd1,   8'd200, 1'b0, 16'd200,  "w8.one");
        op8(8'd128, 8'd2,   1'b0, 16'h0100, "w8.carry");
        op8(8'd170, 8'd85,  1'b0, 16'd14450, "w8.alt");
`ifdef MULT_SIGNED_EN
        op8(8'h80, 8'h80, 1'b1, 16'h4000, "w8.s_minmin");
        op8(8'h80, 8'h7F, 1'b1, 16'hC080, "w8.s_minmax");
        op8(8'hFF, 8'hFF, 1'b1, 16'h0001, "w8.s_m1m1");
        op8(8'hFF, 8'h01, 1'b1, 16'hFFFF, "w8.s_m1p1");
`endif

        // WIDTH=8 random operands against a reference product
        for (int i = 0; i < 300; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
`ifdef MULT_SIGNED_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'($urandom_range(0, 1));
`endif
            ep = {8'h00, ra} * {8'h00, rb};
`ifdef MULT_SIGNED_EN
            if (rs) ep = {{8{ra[7]}}, ra} * {{8{rb[7]}}, rb};
`endif
            op8(ra, rb, rs, ep, "w8.rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
